bomb_display: RTL and testbench
===============================

# bomb_display

Display back end for the countdown timer. Consumes the three BCD digits and the controller's `game_state` byte, and drives three active-low seven-segment digits. Adds leading-zero blanking, a low-time blink, and terminal-state patterns. Raises a one-cycle `time_up` pulse to the controller when an armed countdown reaches 000.

## Interface
- `BLINK_HALF`, default 12_500_000: clock cycles per blink half-period (250 ms at 50 MHz).
- `LOW_THRESH`, default 10: seconds; an armed value below this (and nonzero) blinks.
- `clk`  in  1  on-board 50 MHz clock
- `reset`  in  1  one clock; reset is synchronous and active-high
- `game_state`  in  8  controller state: 8'h10 armed, 8'h20 defused, 8'h30 detonated, anything else idle
- `value_three`  in  4  hundreds BCD digit
- `value_two`  in  4  tens BCD digit
- `value_one`  in  4  units BCD digit
- `hex2`  out  7  hundreds segments, bit0=a … bit6=g, active-low
- `hex1`  out  7  tens segments
- `hex0`  out  7  units segments
- `low_time`  out  1  level; armed and 0 < value < LOW_THRESH
- `time_up`  out  1  one-cycle pulse when the armed countdown reaches 000

## Operation
- **Input stage.** Every cycle, all inputs are registered into a snapshot. All logic works on the snapshot.
- **Value.** value = 100·three + 10·two + one, 10-bit unsigned. Any digit > 9 marks the snapshot invalid; low_time and time_up are never raised from an invalid snapshot.
- **Segment patterns (active-low, g..a).**
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Dash = 0111111. Blank = 1111111.
  - A digit > 9 displays as dash.
- **Blink generator.**
  - Counter runs 0..BLINK_HALF−1. On wrap, `phase` toggles.
  - On any FSM state change, the counter clears to 0 and `phase` is set to on.
  - "Off" phase forces the affected digits to blank.
- **FSM states.**
  - **IDLE.** All digits blank; low_time=0.
  - **ARMED.**
    - Digits are shown decoded.
    - hex2 is blank if three==0. hex1 is blank if three==0 and two==0. hex0 is always shown.
    - If low_time=1, all shown digits blink.
    - `seen_nz` is set once any valid nonzero value is observed.
  - **EXPIRED.** Displays 000 (no blanking), blinking; low_time=0.
  - **DEFUSED.** Shows the snapshot digits steady, no blanking, no blink.
  - **DETONATED.** Displays "---", blinking.
- **Transitions.** Evaluated every cycle.
  - Any state → IDLE, DEFUSED or DETONATED when game_state is other / 8'h20 / 8'h30 respectively.
  - IDLE, DEFUSED or DETONATED → ARMED on 8'h10. Entering ARMED clears `seen_nz`.
  - ARMED → EXPIRED when the snapshot is valid 000 and `seen_nz`=1. `time_up` pulses on that transition only.
  - EXPIRED stays EXPIRED while game_state=8'h10. A new time_up requires leaving 8'h10 and re-arming.
  - Arming with an initial 000 (`seen_nz`=0) stays ARMED, shows 0, and raises no time_up.

## Timing
- **Reset.** hex2/hex1/hex0 = 7'h7F, low_time=0, time_up=0, FSM=IDLE, blink counter=0, phase=on, seen_nz=0. Reset has priority over all other events.
- **Latency.** Inputs sampled at edge N appear on hex*/low_time/time_up after edge N+1 (2-cycle latency). All outputs are registered.
- **time_up.** High for exactly one cycle, in the same cycle the display first shows the EXPIRED pattern.
- **Simultaneous events.** A game_state change in the same snapshot as value 000 takes the game_state transition; no time_up is raised.
- **Blink period.** 2·BLINK_HALF cycles. The first off phase begins BLINK_HALF cycles after state entry or reset.
- **Blink vs low_time.** Entering low_time inside ARMED does not restart the blink counter; the display follows the current phase.

## Test plan
- **Reset.** Reset high 3 cycles with game_state=8'h10 and digits 1,2,0 -> hex* = 7'h7F, time_up=0 during reset. Two cycles after release: hex2=1111001, hex1=0100100, hex0=1000000.
- **Leading-zero blank and blink.** BLINK_HALF=4; armed; digits 0,0,5 -> hex2=hex1=blank, low_time=1, hex0 alternates 0010010 / blank every 4 cycles.
- **Countdown expiry.** Armed digits step 0,0,1 → 0,0,0 -> exactly one time_up pulse, 2 cycles after 000 is applied. low_time falls. Display blinks 000. Holding 8'h10 for 100 more cycles gives no further pulse.
- **Arm at zero.** Arm with digits 0,0,0 from IDLE -> no time_up, hex0=1000000 steady.
- **Terminal states.** game_state=8'h30 -> "---" blinking. Then 8'h20 with digits 0,4,2 -> hex2=1000000, hex1=0011001, hex0=0100100, steady.
- **Invalid digit and mid-blink reset.** value_one=4'hA while armed -> hex0=0111111, low_time=0. Reset asserted during an off phase -> next output all 7'h7F and counter restarted.

Source files
------------

// File: rtl/bomb_display.sv
// Countdown display back end: registers the BCD digits and controller state, then drives three
// active-low seven-segment digits with leading-zero blanking, low-time blink and end-state patterns.
module bomb_display #(
    parameter int unsigned BLINK_HALF = 12_500_000,
    parameter int unsigned LOW_THRESH = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] game_state,
    input  logic [3:0] value_three,
    input  logic [3:0] value_two,
    input  logic [3:0] value_one,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       low_time,
    output logic       time_up
);

    localparam logic [7:0] GsArmed     = 8'h10;
    localparam logic [7:0] GsDefused   = 8'h20;
    localparam logic [7:0] GsDetonated = 8'h30;

    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegDash  = 7'b0111111;
    localparam logic [6:0] SegZero  = 7'b1000000;

    localparam int unsigned CntW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BLINK_HALF - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StExpired,
        StDefused,
        StDetonated
    } state_e;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SegDash;
        endcase
        return s;
    endfunction

    // Input snapshot
    logic [7:0] gs_q;
    logic [3:0] three_q, two_q, one_q;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic            seen_q, seen_d;
    logic [6:0]      hex2_q, hex2_d, hex1_q, hex1_d, hex0_q, hex0_d;
    logic            low_time_q, low_time_d;
    logic            time_up_q, time_up_d;

    logic       valid;
    logic       nz;
    logic [9:0] value;

    always_ff @(posedge clk) begin
        if (reset) begin
            gs_q       <= 8'h00;
            three_q    <= 4'd0;
            two_q      <= 4'd0;
            one_q      <= 4'd0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            phase_q    <= 1'b1;
            seen_q     <= 1'b0;
            hex2_q     <= SegBlank;
            hex1_q     <= SegBlank;
            hex0_q     <= SegBlank;
            low_time_q <= 1'b0;
            time_up_q  <= 1'b0;
        end else begin
            gs_q       <= game_state;
            three_q    <= value_three;
            two_q      <= value_two;
            one_q      <= value_one;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            seen_q     <= seen_d;
            hex2_q     <= hex2_d;
            hex1_q     <= hex1_d;
            hex0_q     <= hex0_d;
            low_time_q <= low_time_d;
            time_up_q  <= time_up_d;
        end
    end

    always_comb begin
        valid = (three_q <= 4'd9) && (two_q <= 4'd9) && (one_q <= 4'd9);
        value = 10'(three_q) * 10'd100 + 10'(two_q) * 10'd10 + 10'(one_q);
        nz    = (value != 10'd0);

        state_d   = state_q;
        seen_d    = seen_q;
        time_up_d = 1'b0;

        if (gs_q == GsArmed) begin
            case (state_q)
                StArmed: begin
                    if (valid && !nz && seen_q) begin
                        state_d   = StExpired;
                        time_up_d = 1'b1;
                    end else if (valid && nz) begin
                        seen_d = 1'b1;
                    end
                end
                StExpired: state_d = StExpired;
                default: begin
                    state_d = StArmed;
                    seen_d  = 1'b0;
                end
            endcase
        end else if (gs_q == GsDefused) begin
            state_d = StDefused;
        end else if (gs_q == GsDetonated) begin
            state_d = StDetonated;
        end else begin
            state_d = StIdle;
        end

        // A state change restarts the blink so every new state opens with an on phase
        if (state_d != state_q) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == CntLast) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
            phase_d = phase_q;
        end

        low_time_d = (state_d == StArmed) && valid && nz && (32'(value) < LOW_THRESH);

        hex2_d = SegBlank;
        hex1_d = SegBlank;
        hex0_d = SegBlank;
        case (state_d)
            StArmed: begin
                if (!low_time_d || phase_d) begin
                    hex2_d = (three_q == 4'd0) ? SegBlank : seg7(three_q);
                    hex1_d = (three_q == 4'd0 && two_q == 4'd0) ? SegBlank : seg7(two_q);
                    hex0_d = seg7(one_q);
                end
            end
            StExpired: begin
                if (phase_d) begin
                    hex2_d = SegZero;
                    hex1_d = SegZero;
                    hex0_d = SegZero;
                end
            end
            StDefused: begin
                hex2_d = seg7(three_q);
                hex1_d = seg7(two_q);
                hex0_d = seg7(one_q);
            end
            StDetonated: begin
                if (phase_d) begin
                    hex2_d = SegDash;
                    hex1_d = SegDash;
                    hex0_d = SegDash;
                end
            end
            default: ;
        endcase
    end

    assign hex2     = hex2_q;
    assign hex1     = hex1_q;
    assign hex0     = hex0_q;
    assign low_time = low_time_q;
    assign time_up  = time_up_q;

endmodule

// File: tb/tb_bomb_display.sv
// Directed bench for bomb_display with a short blink half-period; expected patterns hand-computed.
module tb_bomb_display;

    localparam logic [6:0] SBlank = 7'b1111111;
    localparam logic [6:0] SDash  = 7'b0111111;
    localparam logic [6:0] S0     = 7'b1000000;
    localparam logic [6:0] S1     = 7'b1111001;
    localparam logic [6:0] S2     = 7'b0100100;
    localparam logic [6:0] S4     = 7'b0011001;
    localparam logic [6:0] S5     = 7'b0010010;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] game_state;
    logic [3:0] value_three, value_two, value_one;
    logic [6:0] hex2, hex1, hex0;
    logic       low_time, time_up;

    int n_cmp = 0;
    int n_err = 0;

    bomb_display #(
        .BLINK_HALF(4),
        .LOW_THRESH(10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .game_state (game_state),
        .value_three(value_three),
        .value_two  (value_two),
        .value_one  (value_one),
        .hex2       (hex2),
        .hex1       (hex1),
        .hex0       (hex0),
        .low_time   (low_time),
        .time_up    (time_up)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_hex(input string tag, input logic [6:0] e2, input logic [6:0] e1,
                             input logic [6:0] e0);
        check_eq({tag, "_hex2"}, 32'(hex2), 32'(e2));
        check_eq({tag, "_hex1"}, 32'(hex1), 32'(e1));
        check_eq({tag, "_hex0"}, 32'(hex0), 32'(e0));
    endtask

    task automatic set_in(input logic [7:0] gs, input logic [3:0] d3, input logic [3:0] d2,
                          input logic [3:0] d1);
        game_state  = gs;
        value_three = d3;
        value_two   = d2;
        value_one   = d1;
    endtask

    initial begin
        int pulses;
        logic [6:0] e0;

        reset = 1'b1;
        set_in(8'h10, 4'd1, 4'd2, 4'd0);

        // Reset
        step(1);
        check_hex("rst_a", SBlank, SBlank, SBlank);
        check_eq("rst_a_time_up", 32'(time_up), 0);
        step(2);
        check_hex("rst_b", SBlank, SBlank, SBlank);
        check_eq("rst_b_time_up", 32'(time_up), 0);
        check_eq("rst_b_low_time", 32'(low_time), 0);
        reset = 1'b0;
        step(2);
        check_hex("arm120", S1, S2, S0);
        check_eq("arm120_low_time", 32'(low_time), 0);

        // Idle then leading-zero blank and low-time blink
        set_in(8'h00, 4'd1, 4'd2, 4'd0);
        step(2);
        check_hex("idle", SBlank, SBlank, SBlank);
        set_in(8'h10, 4'd0, 4'd0, 4'd5);
        step(2);
        check_eq("lz_low_time", 32'(low_time), 1);
        for (int i = 0; i < 12; i++) begin
            e0 = (((i / 4) % 2) == 0) ? S5 : SBlank;
            check_hex($sformatf("blink%0d", i), SBlank, SBlank, e0);
            step(1);
        end

        // Countdown expiry
        set_in(8'h10, 4'd0, 4'd0, 4'd1);
        step(2);
        check_eq("cd001_low_time", 32'(low_time), 1);
        check_eq("cd001_time_up", 32'(time_up), 0);
        set_in(8'h10, 4'd0, 4'd0, 4'd0);
        step(1);
        check_eq("exp_early_time_up", 32'(time_up), 0);
        step(1);
        check_eq("exp_time_up", 32'(time_up), 1);
        check_eq("exp_low_time", 32'(low_time), 0);
        check_hex("exp_on", S0, S0, S0);
        step(1);
        check_eq("exp_pulse_end", 32'(time_up), 0);
        step(3);
        check_hex("exp_off", SBlank, SBlank, SBlank);
        pulses = 0;
        repeat (100) begin
            step(1);
            if (time_up) pulses++;
        end
        check_eq("exp_no_repulse", 32'(pulses), 0);

        // Arm at zero
        set_in(8'h00, 4'd0, 4'd0, 4'd0);
        step(2);
        set_in(8'h10, 4'd0, 4'd0, 4'd0);
        pulses = 0;
        step(2);
        for (int i = 0; i < 10; i++) begin
            if (time_up) pulses++;
            check_hex($sformatf("zero%0d", i), SBlank, SBlank, S0);
            step(1);
        end
        check_eq("zero_no_time_up", 32'(pulses), 0);

        // Terminal states
        set_in(8'h30, 4'd0, 4'd0, 4'd0);
        step(2);
        check_hex("det_on", SDash, SDash, SDash);
        step(4);
        check_hex("det_off", SBlank, SBlank, SBlank);
        step(4);
        check_hex("det_on2", SDash, SDash, SDash);
        set_in(8'h20, 4'd0, 4'd4, 4'd2);
        step(2);
        for (int i = 0; i < 10; i++) begin
            check_hex($sformatf("def%0d", i), S0, S4, S2);
            step(1);
        end

        // Invalid digit
        set_in(8'h10, 4'd0, 4'd0, 4'hA);
        step(2);
        check_hex("inv", SBlank, SBlank, SDash);
        check_eq("inv_low_time", 32'(low_time), 0);
        check_eq("inv_time_up", 32'(time_up), 0);

        // Reset in the middle of an off phase
        set_in(8'h30, 4'd0, 4'd0, 4'd0);
        step(2);
        check_hex("mid_on", SDash, SDash, SDash);
        step(4);
        check_hex("mid_off", SBlank, SBlank, SBlank);
        reset = 1'b1;
        step(1);
        check_hex("mid_rst", SBlank, SBlank, SBlank);
        reset = 1'b0;
        step(1);
        check_hex("mid_rel1", SBlank, SBlank, SBlank);
        step(1);
        check_hex("mid_rel2", SDash, SDash, SDash);
        step(3);
        check_hex("mid_rel5", SDash, SDash, SDash);
        step(1);
        check_hex("mid_rel6", SBlank, SBlank, SBlank);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
